// File: rtl/posx_pkg.sv
// Shared encodings for the horizontal-axis movement FSM and the position tracker.
package posx_pkg;

  localparam logic [1:0] MOV_INC  = 2'b10;
  localparam logic [1:0] MOV_DEC  = 2'b01;
  localparam logic [1:0] MOV_HOLD = 2'b00;

  typedef enum logic [1:0] {
    DwIdle  = 2'd0,
    DwDwell = 2'd1,
    DwFire  = 2'd2,
    DwHold  = 2'd3
  } dwell_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: emits a registered one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic s
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      s     <= 1'b0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
      s     <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
      s     <= 1'b0;
    end
  end

endmodule

// File: rtl/posx_tracker.sv
// Saturating X position register with min/max flags, step tick and a one-shot
// dwell-done pulse after the object has rested at POS_MAX for DWELL_TICKS ticks.
module posx_tracker
  import posx_pkg::*;
#(
  parameter int unsigned POS_W       = 8,
  parameter int unsigned POS_MIN     = 0,
  parameter int unsigned POS_MAX     = 159,
  parameter int unsigned POS_INIT    = 80,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DWELL_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_signal,
  input  logic             clr,
  output logic [POS_W-1:0] o_pos,
  output logic             mn,
  output logic             mx,
  output logic             s,
  output logic             cont
);

  localparam int unsigned DwW = $clog2(DWELL_TICKS + 1);
  localparam logic [POS_W-1:0] PosMin  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] PosMax  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] PosInit = POS_W'(POS_INIT);
  localparam logic [DwW-1:0]   DwLast  = DwW'(DWELL_TICKS - 1);

  dwell_state_e   state_q;
  logic [DwW-1:0] dwell_cnt_q;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_prescaler (
    .clk(clk),
    .rst(rst),
    .s  (s)
  );

  assign mn = (o_pos == PosMin);
  assign mx = (o_pos == PosMax);

  // Bounds are checked before the step, so the arithmetic never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      o_pos <= PosInit;
    end else if (i_signal == MOV_INC && o_pos != PosMax) begin
      o_pos <= o_pos + POS_W'(1);
    end else if (i_signal == MOV_DEC && o_pos != PosMin) begin
      o_pos <= o_pos - POS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= DwIdle;
      dwell_cnt_q <= '0;
      cont        <= 1'b0;
    end else begin
      cont <= 1'b0;
      unique case (state_q)
        DwIdle: begin
          // A tick coinciding with arrival at POS_MAX is deliberately ignored.
          if (mx) begin
            state_q     <= DwDwell;
            dwell_cnt_q <= '0;
          end
        end
        DwDwell: begin
          if (!mx) begin
            state_q <= DwIdle;
          end else if (s) begin
            if (dwell_cnt_q == DwLast) begin
              state_q <= DwFire;
              cont    <= 1'b1;
            end else begin
              dwell_cnt_q <= dwell_cnt_q + DwW'(1);
            end
          end
        end
        DwFire: state_q <= DwHold;
        DwHold: begin
          if (!mx) state_q <= DwIdle;
        end
        default: state_q <= DwIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_posx_tracker.sv
// Directed bench for posx_tracker with a small geometry (0..5, init 2, tick every 4, dwell 3).
module tb_posx_tracker;

  localparam logic [1:0] INC = 2'b10;
  localparam logic [1:0] DEC = 2'b01;
  localparam logic [1:0] HLD = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_signal = 2'b00;
  logic       clr = 1'b0;
  logic [7:0] o_pos;
  logic       mn, mx, s, cont;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;  // edges since reset was last released

  posx_tracker #(
    .POS_W      (8),
    .POS_MIN    (0),
    .POS_MAX    (5),
    .POS_INIT   (2),
    .TICK_DIV   (4),
    .DWELL_TICKS(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_signal(i_signal),
    .clr     (clr),
    .o_pos   (o_pos),
    .mn      (mn),
    .mx      (mx),
    .s       (s),
    .cont    (cont)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s ncyc=%0d got=%0d exp=%0d", tag, ncyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) ncyc = 0;
    else ncyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    i_signal = HLD;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (ncyc < n) tick();
  endtask

  // Drive INC for n edges starting now, then return to hold.
  task automatic inc_n(input int n);
    i_signal = INC;
    for (int i = 0; i < n; i++) tick();
    i_signal = HLD;
  endtask

  // Run up to ncyc == last, expecting exactly one cont pulse at ncyc == fire (0 = none).
  task automatic check_cont_until(input string tag, input int last, input int fire);
    while (ncyc < last) begin
      tick();
      check_eq(tag, 32'(cont), 32'(ncyc == fire));
    end
  endtask

  int inc_exp[6] = '{3, 4, 5, 5, 5, 5};
  int dec_exp[3] = '{1, 0, 0};

  initial begin
    // 1. Reset values and tick cadence
    do_reset();
    check_eq("rst_pos", 32'(o_pos), 32'd2);
    check_eq("rst_mn", 32'(mn), 32'd0);
    check_eq("rst_mx", 32'(mx), 32'd0);
    check_eq("rst_cont", 32'(cont), 32'd0);
    check_eq("rst_s", 32'(s), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check_eq("s_cadence", 32'(s), 32'(i % 4 == 0));
    end

    // 2. Saturating increments and decrements
    do_reset();
    for (int i = 0; i < 6; i++) begin
      i_signal = INC;
      tick();
      i_signal = HLD;
      check_eq("inc_pos", 32'(o_pos), 32'(inc_exp[i]));
      check_eq("inc_mx", 32'(mx), 32'(i >= 2));
      tick();
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      i_signal = DEC;
      tick();
      i_signal = HLD;
      check_eq("dec_pos", 32'(o_pos), 32'(dec_exp[i]));
      check_eq("dec_mn", 32'(mn), 32'(i >= 1));
      tick();
    end

    // 3a. Reach 5 at edge 3; counted ticks after edges 4,8,12 -> cont after edge 13 only
    do_reset();
    inc_n(3);
    check_eq("dwell_pos", 32'(o_pos), 32'd5);
    check_cont_until("dwell_cont", 30, 13);

    // 3b. Arrive at 5 in the same cycle as a tick: that tick is not counted -> cont at 17
    do_reset();
    tick();
    inc_n(3);
    check_eq("arrive_s", 32'(s), 32'd1);
    check_cont_until("arrive_cont", 24, 17);

    // 4. Leave 5 after two counted ticks, come back, full dwell restarts -> cont at 21
    do_reset();
    inc_n(3);
    wait_to(9);
    i_signal = DEC;
    tick();
    check_eq("abort_pos", 32'(o_pos), 32'd4);
    check_eq("abort_cont", 32'(cont), 32'd0);
    i_signal = INC;
    tick();
    i_signal = HLD;
    check_eq("return_pos", 32'(o_pos), 32'd5);
    check_cont_until("redwell_cont", 28, 21);

    // 5a. clr beats a simultaneous increment
    do_reset();
    inc_n(2);
    check_eq("pre_clr_pos", 32'(o_pos), 32'd4);
    clr = 1'b1;
    i_signal = INC;
    tick();
    clr = 1'b0;
    i_signal = HLD;
    check_eq("clr_pos", 32'(o_pos), 32'd2);

    // 5b. clr on the very edge that would fire cont
    do_reset();
    inc_n(3);
    wait_to(12);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_cont", 32'(cont), 32'd0);
    check_eq("clr_dwell_pos", 32'(o_pos), 32'd2);
    check_cont_until("post_clr_cont", 20, 0);

    // 5c. rst mid-dwell restores everything, including the prescaler phase
    do_reset();
    inc_n(3);
    wait_to(10);
    rst = 1'b1;
    tick();
    check_eq("mrst_pos", 32'(o_pos), 32'd2);
    check_eq("mrst_mx", 32'(mx), 32'd0);
    check_eq("mrst_s", 32'(s), 32'd0);
    check_eq("mrst_cont", 32'(cont), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_eq("mrst_s_phase", 32'(s), 32'(i == 4));
    end

    // 6. Both hold encodings leave the position alone
    do_reset();
    inc_n(1);
    i_signal = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold11_pos", 32'(o_pos), 32'd3);
    end
    i_signal = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold00_pos", 32'(o_pos), 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
